fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Read-side consumer for the 32x8 synchronous FIFO. Whenever the FIFO is non-empty and transmission is enabled, it pops one byte and sends it on a single-wire asynchronous serial line: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It sits between the FIFO read port and the off-chip TX pin, and is the sole reader of that FIFO.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  permits starting new frames; sampled in IDLE only.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO data_out; valid in the cycle after a read strobe accepted while not empty.
- fifo_rd_en  out  1  FIFO read strobe; one-cycle pulse per byte.
- tx  out  1  serial line; idle high.
- busy  out  1  high in every state except IDLE.
- byte_done  out  1  one-cycle pulse in the last cycle of each stop bit.

## Operation
- FSM states: IDLE, REQ, WAIT, START, DATA, STOP.
- IDLE: tx=1. If enable=1 and fifo_empty=0, go to REQ; otherwise stay.
- REQ (1 cycle): fifo_rd_en = (state==REQ) && !fifo_empty.
  - If fifo_empty=0, go to WAIT.
  - If fifo_empty=1, which only happens if the FIFO is externally reset, no strobe is issued; return to IDLE.
- WAIT (1 cycle): capture fifo_data into an 8-bit shift register at the end of the cycle; go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit, shift right and increment the bit index (3 bits, 0..7).
  - After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. byte_done=1 in the final cycle, then go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and clears on every state entry.
- enable is ignored outside IDLE. Deasserting it mid-frame lets the current frame finish; no new REQ follows.
- At most one fifo_rd_en pulse per frame. No strobe is issued while fifo_empty=1.
- Reset, from any state: the next edge gives state=IDLE with counters, bit index and shift register cleared. Any partial frame is dropped; the popped byte is lost.

## Timing
- Reset values: tx=1, busy=0, fifo_rd_en=0, byte_done=0.
- tx is driven from a flop and changes only on the clock edge that enters a state or a new bit. No combinational path from inputs to tx.
- fifo_rd_en and byte_done are decoded from registered state and counters only. fifo_rd_en is additionally gated by fifo_empty.
- Latency, with IDLE seeing fifo_empty=0 in cycle 0:
  - REQ in cycle 1.
  - WAIT in cycle 2.
  - Start bit occupies cycles 3..3+CLKS_PER_BIT-1.
  - byte_done in cycle 2+10*CLKS_PER_BIT.
- Back-to-back frames: period is 10*CLKS_PER_BIT+3 cycles. This includes 3 extra idle-high cycles (IDLE, REQ, WAIT) between the stop bit and the next start bit.
- A FIFO write in the same cycle as a read is the FIFO's concern. This block only requires fifo_data to be valid one cycle after the accepted strobe.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: assert rst 3 cycles with the FIFO holding data -> tx=1, busy=0, fifo_rd_en=0, byte_done=0 throughout.
- Single byte 0xA5, enable=1:
  - fifo_rd_en high exactly in cycle 1.
  - tx per 4-cycle slot from cycle 3: 0,1,0,1,0,0,1,0,1,1.
  - byte_done in cycle 42 only; busy high in cycles 1..42.
- Back-to-back 0x00, 0xFF, 0x3C preloaded:
  - Exactly 3 fifo_rd_en pulses, 43 cycles apart.
  - Decoded line bytes are 0x00, 0xFF, 0x3C.
  - No strobe after the FIFO empties.
- enable control:
  - enable=0 with a non-empty FIFO for 100 cycles -> no strobe, tx=1.
  - Drop enable during DATA -> frame completes, byte_done pulses, no further REQ.
- Reset mid-DATA (bit 3): next cycle tx=1, busy=0. After release with the FIFO non-empty, a fresh REQ occurs 1 cycle later and a full frame follows.
- Force fifo_empty=1 during REQ -> fifo_rd_en stays 0, FSM returns to IDLE, tx stays 1, no byte_done.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// Pops bytes from the 32x8 FIFO and sends them as 8N1 serial frames.
// tx is registered; strobes are decoded from registered state only.
module fifo_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (enable && !fifo_empty) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = fifo_empty ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                shift_d = fifo_data;
                state_d = S_START;
                cnt_d   = '0;
                tx_d    = 1'b0;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        // next bit is the one that moves into shift[0]
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_rd_en = (state_q == S_REQ) && !fifo_empty;
    assign byte_done  = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: queue-backed FIFO model, line decoder,
// directed timing checks and a randomized byte stream.
module tb_fifo_serial_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB + 3;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    fifo_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: write side from the stimulus, read side pops on strobe
    logic [7:0] q[$];
    int         wr_cnt = 0;
    int         rd_idx = 0;
    logic       force_empty = 1'b0;

    assign fifo_empty = force_empty | (rd_idx >= wr_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= q[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    // cycle counter and event logs
    int cyc = 0;
    int rd_log[$];
    int bd_log[$];

    always @(posedge clk) begin
        if (fifo_rd_en) rd_log.push_back(cyc);
        if (byte_done) bd_log.push_back(cyc);
        cyc <= cyc + 1;
    end

    // line decoder: sample at mid-bit after the start edge
    logic [7:0] rx[$];
    logic [7:0] dec_b;
    int         dec_t = 0;
    bit         dec_on = 1'b0;
    int         frame_err = 0;

    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (tx === 1'b0) begin
                dec_on = 1'b1;
                dec_t  = 0;
            end
        end else begin
            dec_t = dec_t + 1;
            if (dec_t >= CPB + CPB / 2 && dec_t < 9 * CPB && dec_t % CPB == CPB / 2)
                dec_b[(dec_t - CPB - CPB / 2) / CPB] = tx;
            if (dec_t == 9 * CPB + CPB / 2) begin
                if (tx !== 1'b1) frame_err = frame_err + 1;
                rx.push_back(dec_b);
                dec_on = 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        wr_cnt = wr_cnt + 1;
    endtask

    function automatic logic exp_tx(input int k, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        if (k < 3 || k >= 3 + 10 * CPB) return 1'b1;
        return fr[(k - 3) / CPB];
    endfunction

    int         c0;
    int         r;
    int         bad;
    int         n;
    int         budget;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        push(8'hA5);

        // reset with data held
        tick(1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || byte_done !== 1'b0)
                bad = bad + 1;
            tick(1);
        end
        chk("reset_outputs", bad, 0);
        rst = 1'b0;
        tick(2);
        chk("reset_no_strobe", rd_log.size(), 0);

        // single byte 0xA5, cycle-by-cycle
        rd_log.delete();
        bd_log.delete();
        rx.delete();
        enable = 1'b1;
        c0 = cyc;
        for (int k = 0; k <= 45; k++) begin
            chk($sformatf("a5_tx_c%0d", k), tx, exp_tx(k, 8'hA5));
            chk($sformatf("a5_busy_c%0d", k), busy, (k >= 1 && k <= 2 + 10 * CPB));
            chk($sformatf("a5_rd_c%0d", k), fifo_rd_en, (k == 1));
            chk($sformatf("a5_done_c%0d", k), byte_done, (k == 2 + 10 * CPB));
            tick(1);
        end
        chk("a5_rx_count", rx.size(), 1);
        if (rx.size() > 0) chk("a5_rx_byte", rx[0], 8'hA5);

        // back-to-back frames
        enable = 1'b0;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        rd_log.delete();
        bd_log.delete();
        rx.delete();
        tick(1);
        enable = 1'b1;
        c0 = cyc;
        tick(3 * FRAME + 20);
        chk("b2b_rd_count", rd_log.size(), 3);
        chk("b2b_done_count", bd_log.size(), 3);
        for (int i = 0; i < 3 && i < rd_log.size(); i++)
            chk($sformatf("b2b_rd_cyc%0d", i), rd_log[i] - c0, 1 + i * FRAME);
        for (int i = 0; i < 3 && i < bd_log.size(); i++)
            chk($sformatf("b2b_done_cyc%0d", i), bd_log[i] - c0, 2 + 10 * CPB + i * FRAME);
        chk("b2b_rx_count", rx.size(), 3);
        if (rx.size() == 3) begin
            chk("b2b_rx0", rx[0], 8'h00);
            chk("b2b_rx1", rx[1], 8'hFF);
            chk("b2b_rx2", rx[2], 8'h3C);
        end

        // enable held low with data waiting
        enable = 1'b0;
        push(8'h5A);
        rd_log.delete();
        bd_log.delete();
        rx.delete();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad = bad + 1;
            tick(1);
        end
        chk("en_low_idle", bad, 0);
        chk("en_low_no_rd", rd_log.size(), 0);

        // drop enable mid-DATA, next byte must stay queued
        push(8'h77);
        enable = 1'b1;
        c0 = cyc;
        tick(10);
        enable = 1'b0;
        tick(60);
        chk("en_drop_rd_count", rd_log.size(), 1);
        if (rd_log.size() > 0) chk("en_drop_rd_cyc", rd_log[0] - c0, 1);
        chk("en_drop_done_count", bd_log.size(), 1);
        if (bd_log.size() > 0) chk("en_drop_done_cyc", bd_log[0] - c0, 2 + 10 * CPB);
        chk("en_drop_rx_count", rx.size(), 1);
        if (rx.size() > 0) chk("en_drop_rx", rx[0], 8'h5A);

        // reset during data bit 3 of 0x77
        push(8'hC3);
        rd_log.delete();
        bd_log.delete();
        rx.delete();
        enable = 1'b1;
        c0 = cyc;
        tick(3 + CPB + 3 * CPB + 1);
        chk("mid_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        r = cyc;
        tick(FRAME + 10);
        chk("mid_rd_count", rd_log.size(), 2);
        if (rd_log.size() == 2) chk("mid_req_after_rst", rd_log[1] - r, 1);
        chk("mid_done_count", bd_log.size(), 1);
        if (bd_log.size() > 0) chk("mid_done_cyc", bd_log[0] - r, 2 + 10 * CPB);
        chk("mid_rx_count", rx.size(), 1);
        if (rx.size() > 0) chk("mid_rx", rx[0], 8'hC3);

        // FIFO reports empty during REQ
        enable = 1'b0;
        push(8'h96);
        rd_log.delete();
        bd_log.delete();
        rx.delete();
        tick(1);
        enable = 1'b1;
        tick(1);
        chk("fe_in_req_busy", busy, 1'b1);
        force_empty = 1'b1;
        #1;
        chk("fe_no_strobe", fifo_rd_en, 1'b0);
        tick(1);
        chk("fe_back_idle", busy, 1'b0);
        chk("fe_tx_high", tx, 1'b1);
        tick(3);
        enable = 1'b0;
        force_empty = 1'b0;
        tick(5);
        chk("fe_rd_log", rd_log.size(), 0);
        chk("fe_done_log", bd_log.size(), 0);
        chk("fe_rx", rx.size(), 0);

        // randomized stream against the FIFO-order model
        exp_q.delete();
        exp_q.push_back(8'h96);
        n = 6 + $urandom_range(0, 3);
        enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            push(b);
            exp_q.push_back(b);
            tick($urandom_range(0, 60));
            enable = ($urandom_range(0, 3) != 0);
        end
        enable = 1'b1;
        budget = (n + 2) * FRAME + 50;
        while (rx.size() < exp_q.size() && budget > 0) begin
            tick(1);
            budget = budget - 1;
        end
        chk("rnd_complete", rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            chk($sformatf("rnd_byte%0d", i), rx[i], exp_q[i]);
        tick(FRAME);
        chk("rnd_rd_count", rd_log.size(), exp_q.size());
        chk("rnd_done_count", bd_log.size(), exp_q.size());
        bad = 0;
        for (int i = 1; i < rd_log.size(); i++)
            if (rd_log[i] - rd_log[i - 1] < FRAME) bad = bad + 1;
        chk("rnd_rd_spacing", bad, 0);
        chk("frame_errors", frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
